dac_bias_restorer: RTL and testbench
====================================

// Module: dac_bias_restorer
// PURPOSE
//  Transmit/DAC-side counterpart of the receive DC blocker.
//  - Takes signed fixed-point samples, rounds them to integer, adds a mid-scale bias, clamps, and emits unsigned DAC codes.
//  - Soft-starts and soft-stops the bias with a per-sample ramp to avoid output pops.
//  - Sits between the TX DSP chain and the DAC interface.
// PARAMETERS
//  OUTPUT_DW        12   unsigned DAC code width
//  INPUT_FRAC_BITS  4    fractional bits of data_i
//  RAMP_STEP        256  bias increment/decrement per accepted sample, in codes (>=1)
// PORTS
//  clk       in   1                            single clock, all logic on posedge
//  rst_n     in   1                            reset, synchronous, active-low
//  data_i    in   OUTPUT_DW+INPUT_FRAC_BITS+1  signed sample, Q(OUTPUT_DW).(INPUT_FRAC_BITS)
//  valid_i   in   1                            sample strobe; one sample per high cycle
//  en_i      in   1                            level: 1 = ramp up/run, 0 = ramp down/off
//  data_o    out  OUTPUT_DW                    unsigned DAC code
//  valid_o   out  1                            data_o strobe
//  active_o  out  1                            high while state == RUN
//  sat_o     out  1                            clip flag, qualified by valid_o
// BEHAVIOUR
//  - MID = 2**(OUTPUT_DW-1).
//  - Reset (rst_n low at posedge): state OFF, bias 0, LFSR reseeded, and all outputs 0:
//    data_o, valid_o, active_o, sat_o.
//  - Latency: valid_o rises exactly 2 clk after each valid_i, in every state. The DAC is always fed. No backpressure.
//  - Stage 1, on valid_i:
//    - r = (data_i + 2**(INPUT_FRAC_BITS-1)) >>> INPUT_FRAC_BITS, i.e. arithmetic round-half-up.
//    - Bias update:
//      - RAMP_UP: bias = min(bias+RAMP_STEP, MID).
//      - RAMP_DOWN: bias = max(bias-RAMP_STEP, 0).
//      - OFF: bias = 0.
//      - RUN: bias = MID.
//    - The current sample uses the updated bias.
//  - Stage 2: s = bias + (state==RUN ? r : 0).
//    - Clamp s to [0, 2**OUTPUT_DW-1].
//    - sat_o = 1 if clamped.
//    - Internal sum is wide enough that no wrap occurs.
//  - States: OFF, RAMP_UP, RUN, RAMP_DOWN.
//    - Transitions are evaluated every clk; bias moves only on valid_i.
//    - OFF       -> RAMP_UP    when en_i=1.
//    - RAMP_UP   -> RUN        on the sample where bias reaches MID.
//    - RAMP_UP   -> RAMP_DOWN  when en_i=0; ramps down from the current bias.
//    - RUN       -> RAMP_DOWN  when en_i=0.
//    - RAMP_DOWN -> RAMP_UP    when en_i=1.
//    - RAMP_DOWN -> OFF        on the sample where bias reaches 0.
//  - Sample-to-state timing: a sample accepted in the same cycle as a state change uses the pre-change state for muting.
//  - Non-divisible ramp: if RAMP_STEP does not divide MID, the final step clamps exactly to MID or 0.
//  - Mid-operation reset: rst_n low mid-ramp or mid-RUN drops to OFF/bias 0 at that edge. In-flight pipeline samples are discarded; valid_o stays 0.
// CONFIGURATION
//  DAC_BIAS_DITHER_EN defined:
//    - The stage-1 rounding constant is replaced by the low INPUT_FRAC_BITS of a 16-bit Fibonacci LFSR.
//    - LFSR taps 16,14,13,11; seed 16'hACE1.
//    - The LFSR advances once per valid_i.
//  Undefined:
//    - Fixed round-half-up as above; no LFSR logic is present.
// TESTING
//  (OUTPUT_DW=12, INPUT_FRAC_BITS=4, RAMP_STEP=256, dither off, valid_i every 4 clk)
//  1. rst_n=0 for 3 clk -> data_o=0, valid_o=0, active_o=0, sat_o=0.
//  2. en_i=1, data_i=0 -> data_o=256,512,...,2048 on 8 strobes; active_o=1 after 8th; valid_o 2 clk after each valid_i.
//  3. RUN, data_i=+16,-24,+8,-8 -> data_o=2049,2047,2049,2048 (half-up rounding), sat_o=0.
//  4. RUN, data_i=+40000 -> data_o=4095, sat_o=1; data_i=-40000 -> data_o=0, sat_o=1.
//  5. en_i=1 then 0 after 3 samples (bias 768) -> data_o=512,256,0, then OFF; data_o stays 0.
//  6. rst_n=0 one clk during RUN -> outputs 0, in-flight strobe dropped; en_i=1 ramps again from 256.

Source files
------------

// File: rtl/dac_bias_restorer.sv
// DAC-side bias restorer: rounds signed samples, adds a soft-ramped mid-scale bias, clamps to DAC codes.
// Define DAC_BIAS_DITHER_EN to replace the round-half-up constant with LFSR dither.
module dac_bias_restorer #(
  parameter int unsigned OUTPUT_DW       = 12,
  parameter int unsigned INPUT_FRAC_BITS = 4,
  parameter int unsigned RAMP_STEP       = 256
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic signed [OUTPUT_DW+INPUT_FRAC_BITS:0] data_i,
  input  logic                                     valid_i,
  input  logic                                     en_i,
  output logic        [OUTPUT_DW-1:0]              data_o,
  output logic                                     valid_o,
  output logic                                     active_o,
  output logic                                     sat_o
);

  localparam int unsigned InW     = OUTPUT_DW + INPUT_FRAC_BITS + 1;
  localparam int unsigned SumW    = InW + 1;
  localparam int unsigned BiasW   = OUTPUT_DW;
  localparam int unsigned HalfInt = 2 ** (INPUT_FRAC_BITS - 1);

  localparam logic [BiasW-1:0]       Mid       = BiasW'(2 ** (OUTPUT_DW - 1));
  localparam logic [BiasW-1:0]       RampStepW = BiasW'(RAMP_STEP);
  localparam logic signed [SumW:0]   MaxCode   = (SumW + 1)'((2 ** OUTPUT_DW) - 1);

  typedef enum logic [1:0] {StOff, StRampUp, StRun, StRampDown} state_e;

  state_e                   state_q, state_d;
  logic [BiasW-1:0]         bias_q;
  logic [BiasW-1:0]         bias_nxt;
  logic [BiasW-1:0]         bias_up;
  logic [BiasW-1:0]         bias_down;
  logic [31:0]              up_wide;

  logic [INPUT_FRAC_BITS-1:0] round_k;
  logic signed [SumW-1:0]     pre_round;
  logic signed [SumW-1:0]     rounded;

  logic                     s1_valid_q;
  logic [BiasW-1:0]         s1_bias_q;
  logic signed [SumW-1:0]   s1_r_q;

  logic signed [SumW:0]     s2_sum;
  logic [OUTPUT_DW-1:0]     s2_code;
  logic                     s2_sat;

`ifdef DAC_BIAS_DITHER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Fibonacci taps 16,14,13,11; advances once per accepted sample
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign round_k = lfsr_q[INPUT_FRAC_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
    end else if (valid_i) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign round_k = HalfInt[INPUT_FRAC_BITS-1:0];
`endif

  // Sign-extend one bit so the rounding add can never wrap
  assign pre_round = {data_i[InW-1], data_i} + {{(SumW - INPUT_FRAC_BITS){1'b0}}, round_k};
  assign rounded   = pre_round >>> INPUT_FRAC_BITS;

  always_comb begin
    up_wide = {{(32 - BiasW){1'b0}}, bias_q} + 32'(RAMP_STEP);
    if (up_wide >= {{(32 - BiasW){1'b0}}, Mid}) begin
      bias_up = Mid;
    end else begin
      bias_up = up_wide[BiasW-1:0];
    end

    if ({{(32 - BiasW){1'b0}}, bias_q} <= 32'(RAMP_STEP)) begin
      bias_down = '0;
    end else begin
      bias_down = bias_q - RampStepW;
    end

    bias_nxt = bias_q;
    unique case (state_q)
      StOff:      bias_nxt = '0;
      StRampUp:   bias_nxt = bias_up;
      StRun:      bias_nxt = Mid;
      StRampDown: bias_nxt = bias_down;
      default:    bias_nxt = '0;
    endcase
  end

  // Enable level wins over a ramp reaching its end on the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (en_i) state_d = StRampUp;
      end
      StRampUp: begin
        if (!en_i) begin
          state_d = StRampDown;
        end else if (valid_i && (bias_nxt == Mid)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!en_i) state_d = StRampDown;
      end
      StRampDown: begin
        if (en_i) begin
          state_d = StRampUp;
        end else if (valid_i && (bias_nxt == '0)) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    s2_sum = $signed({{(SumW + 1 - BiasW){1'b0}}, s1_bias_q}) + $signed({s1_r_q[SumW-1], s1_r_q});
    if (s2_sum[SumW]) begin
      s2_code = '0;
      s2_sat  = 1'b1;
    end else if (s2_sum > MaxCode) begin
      s2_code = '1;
      s2_sat  = 1'b1;
    end else begin
      s2_code = s2_sum[OUTPUT_DW-1:0];
      s2_sat  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StOff;
      bias_q     <= '0;
      active_o   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_bias_q  <= '0;
      s1_r_q     <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      sat_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_o   <= (state_d == StRun);
      s1_valid_q <= valid_i;
      valid_o    <= s1_valid_q;
      if (valid_i) begin
        bias_q    <= bias_nxt;
        s1_bias_q <= bias_nxt;
        // Muting follows the state the sample was accepted in, not the one it causes
        s1_r_q    <= (state_q == StRun) ? rounded : '0;
      end
      if (s1_valid_q) begin
        data_o <= s2_code;
        sat_o  <= s2_sat;
      end
    end
  end

endmodule

// File: tb/tb_dac_bias_restorer.sv
// Self-checking bench for dac_bias_restorer: directed scenarios plus randomized samples vs a sample-level model.
module tb_dac_bias_restorer;

  localparam int Mid  = 2048;
  localparam int Step = 256;
  localparam int MaxC = 4095;

  logic               clk;
  logic               rst_n;
  logic signed [16:0] data_i;
  logic               valid_i;
  logic               en_i;
  logic [11:0]        data_o;
  logic               valid_o;
  logic               active_o;
  logic               sat_o;

  int checks;
  int failures;

  dac_bias_restorer #(
    .OUTPUT_DW      (12),
    .INPUT_FRAC_BITS(4),
    .RAMP_STEP      (256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .en_i    (en_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .active_o(active_o),
    .sat_o   (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=off 1=ramping up 2=running 3=ramping down
  int m_mode;
  int m_bias;
  int m_nb;
  int m_r;
  int m_s;
  int m_in;
  int exp_data[$];
  bit exp_sat[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0;
      m_bias = 0;
      exp_data.delete();
      exp_sat.delete();
    end else begin
      m_nb = m_bias;
      if (valid_i) begin
        if (m_mode == 0) m_nb = 0;
        else if (m_mode == 1) m_nb = (m_bias + Step > Mid) ? Mid : m_bias + Step;
        else if (m_mode == 2) m_nb = Mid;
        else m_nb = (m_bias - Step < 0) ? 0 : m_bias - Step;
        m_in = data_i;
        m_r  = $rtoi($floor(real'(m_in) / 16.0 + 0.5));
        m_s  = m_nb + ((m_mode == 2) ? m_r : 0);
        exp_sat.push_back(m_s < 0 || m_s > MaxC);
        exp_data.push_back(m_s < 0 ? 0 : (m_s > MaxC ? MaxC : m_s));
      end
      case (m_mode)
        0: if (en_i) m_mode = 1;
        1: if (!en_i) m_mode = 3; else if (valid_i && m_nb == Mid) m_mode = 2;
        2: if (!en_i) m_mode = 3;
        default: if (en_i) m_mode = 1; else if (valid_i && m_nb == 0) m_mode = 0;
      endcase
      m_bias = m_nb;
    end
  end

  // Applies one sample and captures outputs at +1, +2 and +3 clocks; spacing is 4 clocks.
  task automatic send(input logic signed [16:0] d, output int od, output bit os,
                      output bit v1, output bit v2, output bit v3, output bit act,
                      output int ed, output bit es, output bit erun);
    @(negedge clk);
    data_i  = d;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    v1 = valid_o;
    erun = (m_mode == 2);
    if (exp_data.size() > 0) begin
      ed = exp_data.pop_front();
      es = exp_sat.pop_front();
    end else begin
      ed = -1;
      es = 1'b0;
    end
    @(negedge clk);
    v2  = valid_o;
    od  = data_o;
    os  = sat_o;
    act = active_o;
    @(negedge clk);
    v3 = valid_o;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_o !== 12'd0) begin failures++; $display("FAIL reset_data got=%0d exp=0", data_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
    checks++; if (active_o !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", active_o); end
    checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_up();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    @(negedge clk);
    en_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(17'sd0, od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== 256 * k || od !== ed) begin failures++;
        $display("FAIL ramp_up_data k=%0d got=%0d exp=%0d model=%0d", k, od, 256 * k, ed); end
      checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || v3 !== 1'b0) begin failures++;
        $display("FAIL ramp_up_latency k=%0d got=%0b%0b%0b exp=010", k, v1, v2, v3); end
      checks++; if (act !== (k == 8)) begin failures++;
        $display("FAIL ramp_up_active k=%0d got=%0b exp=%0b", k, act, (k == 8)); end
    end
  endtask

  task automatic test_rounding();
    logic signed [16:0] ins [4];
    int outs [4];
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    ins[0] = 17'sd16; ins[1] = -17'sd24; ins[2] = 17'sd8; ins[3] = -17'sd8;
    outs[0] = 2049; outs[1] = 2047; outs[2] = 2049; outs[3] = 2048;
    for (int i = 0; i < 4; i++) begin
      send(ins[i], od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== outs[i] || od !== ed || os !== 1'b0) begin failures++;
        $display("FAIL rounding i=%0d got=%0d sat=%0b exp=%0d sat=0", i, od, os, outs[i]); end
    end
  endtask

  task automatic test_saturation();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    send(17'sd40000, od, os, v1, v2, v3, act, ed, es, erun);
    checks++; if (od !== 4095 || os !== 1'b1 || od !== ed || os !== es) begin failures++;
      $display("FAIL sat_high got=%0d sat=%0b exp=4095 sat=1", od, os); end
    send(-17'sd40000, od, os, v1, v2, v3, act, ed, es, erun);
    checks++; if (od !== 0 || os !== 1'b1 || od !== ed || os !== es) begin failures++;
      $display("FAIL sat_low got=%0d sat=%0b exp=0 sat=1", od, os); end
    send(17'sd32767, od, os, v1, v2, v3, act, ed, es, erun);
    checks++; if (od !== 4095 || os !== 1'b1) begin failures++;
      $display("FAIL sat_edge got=%0d sat=%0b exp=4095 sat=1", od, os); end
  endtask

  task automatic test_random_run();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    logic signed [16:0] d;
    for (int i = 0; i < 24; i++) begin
      d = (i % 3 == 0) ? 17'($urandom_range(0, 131071)) : 17'($signed($urandom_range(0, 65535)) - 32768);
      send(d, od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== ed || os !== es || v2 !== 1'b1 || act !== 1'b1) begin failures++;
        $display("FAIL random_run d=%0d got=%0d sat=%0b v=%0b act=%0b exp=%0d sat=%0b", d, od, os, v2, act, ed, es); end
    end
  endtask

  task automatic test_ramp_down();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    @(negedge clk);
    en_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      send(17'($urandom_range(0, 131071)), od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== ((k < 8) ? 2048 - 256 * k : 0) || od !== ed || act !== 1'b0) begin failures++;
        $display("FAIL ramp_down k=%0d got=%0d act=%0b exp=%0d", k, od, act, (k < 8) ? 2048 - 256 * k : 0); end
    end
  endtask

  task automatic test_ramp_abort();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    int exp_seq [8];
    exp_seq = '{256, 512, 768, 512, 256, 0, 0, 0};
    @(negedge clk);
    en_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        @(negedge clk);
        en_i = 1'b0;
      end
      send(17'sd100, od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== exp_seq[k] || od !== ed || act !== 1'b0) begin failures++;
        $display("FAIL ramp_abort k=%0d got=%0d act=%0b exp=%0d", k, od, act, exp_seq[k]); end
    end
  endtask

  task automatic test_random_en();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      en_i = ($urandom_range(0, 3) != 0);
      send(17'($urandom_range(0, 131071)), od, os, v1, v2, v3, act, ed, es, erun);
      checks++; if (od !== ed || os !== es || act !== erun) begin failures++;
        $display("FAIL random_en i=%0d got=%0d sat=%0b act=%0b exp=%0d sat=%0b act=%0b", i, od, os, act, ed, es, erun); end
    end
  endtask

  task automatic test_mid_reset();
    int od, ed; bit os, es, v1, v2, v3, act, erun;
    bit seen;
    @(negedge clk);
    en_i = 1'b1;
    for (int k = 0; k < 9; k++) send(17'sd0, od, os, v1, v2, v3, act, ed, es, erun);
    checks++; if (active_o !== 1'b1) begin failures++; $display("FAIL mid_reset_prerun got=%0b exp=1", active_o); end
    @(negedge clk);
    data_i  = 17'sd800;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (data_o !== 12'd0 || sat_o !== 1'b0 || active_o !== 1'b0) begin failures++;
      $display("FAIL mid_reset_outputs got data=%0d sat=%0b act=%0b exp 0 0 0", data_o, sat_o, active_o); end
    seen = valid_o;
    repeat (3) begin
      @(negedge clk);
      seen |= valid_o;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_reset_dropped got=%0b exp=0", seen); end
    send(17'sd0, od, os, v1, v2, v3, act, ed, es, erun);
    checks++; if (od !== 256 || od !== ed || v2 !== 1'b1) begin failures++;
      $display("FAIL mid_reset_restart got=%0d v=%0b exp=256 v=1", od, v2); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    data_i   = '0;
    valid_i  = 1'b0;
    en_i     = 1'b0;
    test_reset();
    test_ramp_up();
    test_rounding();
    test_saturation();
    test_random_run();
    test_ramp_down();
    test_ramp_abort();
    test_random_en();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
